// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: requester count,
// index width and the arbiter state encoding.
package rr_arbiter_8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter_8_gnt_decoder.sv
// 3-to-8 one-hot decoder with enable, built from gate primitives so the
// grant lines are a pure AND of registered index bits and the valid flag.
module gnt_decoder
    import rr_arbiter_8_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N_REQ-1:0] y
);

    wire [IDX_W-1:0] idx_n;
    wire [N_REQ-1:0] y_w;

    not u_inv0 (idx_n[0], idx[0]);
    not u_inv1 (idx_n[1], idx[1]);
    not u_inv2 (idx_n[2], idx[2]);

    // Each output ANDs the enable with the true/complement index bits matching its position.
    for (genvar i = 0; i < N_REQ; i++) begin : g_row
        localparam logic [IDX_W-1:0] SEL = IDX_W'(i);
        and u_and (y_w[i], en,
                   SEL[0] ? idx[0] : idx_n[0],
                   SEL[1] ? idx[1] : idx_n[1],
                   SEL[2] ? idx[2] : idx_n[2]);
    end

    assign y = y_w;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters: grants are held until done, request
// drop or timeout, then priority rotates past the last owner.
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);

    state_t           state_q,     state_d;
    logic [IDX_W-1:0] ptr_q,       ptr_d;
    logic [IDX_W-1:0] gnt_idx_q,   gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [CNT_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic             preempt_q,   preempt_d;

    logic             owner_release;
    logic             hold_expired;

    // First set request bit scanning upward from p, wrapping modulo 8.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] win;
        logic             found;
        win   = p;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = p + IDX_W'(k);
            if (!found && r[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign owner_release = done || !req[gnt_idx_q];
    assign hold_expired  = (hold_cnt_q == CNT_W'(HOLD_MAX - 1));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        hold_cnt_d  = hold_cnt_q;
        preempt_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req != '0) begin
                    gnt_idx_d   = rr_pick(req, ptr_q);
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A normal release wins over a coincident timeout, so preempt only flags pure timeouts.
                if (owner_release || hold_expired) begin
                    state_d     = ST_IDLE;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    ptr_d       = gnt_idx_q + IDX_W'(1);
                    preempt_d   = !owner_release;
                end else begin
                    hold_cnt_d  = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            hold_cnt_q  <= '0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            hold_cnt_q  <= hold_cnt_d;
            preempt_q   <= preempt_d;
        end
    end

    gnt_decoder u_gnt_decoder (
        .idx (gnt_idx_q),
        .en  (gnt_valid_q),
        .y   (gnt)
    );

    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign preempt   = preempt_q;

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
Round-robin arbiter that shares one resource among 8 requesters. It picks a requester, holds the grant until release or timeout, then rotates priority. The registered 3-bit winner index drives a 3-to-8 decoder, which produces the one-hot grant bus for the downstream enable lines. The block sits between the requester bank and the shared datapath enable.

Parameters:
HOLD_MAX, 15, maximum cycles one grant may be held before forced release (legal range 2..15).
CNT_W, 4, hold counter width; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous reset, active-low
req  in  8  request lines, bit i = requester i, level-sensitive
done  in  1  current owner releases the resource; sampled only in GRANT
gnt  out  8  one-hot grant; all zero when gnt_valid=0
gnt_idx  out  3  index of current owner; valid only when gnt_valid=1
gnt_valid  out  1  a grant is active
preempt  out  1  one-cycle pulse when a grant ends by timeout

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, ptr=0, gnt_idx=0, gnt_valid=0, gnt=8'h00, preempt=0, hold_cnt=0.
- Reset asserted mid-grant drops gnt and gnt_valid immediately (asynchronous); nothing is retained.
- Registered state: state {IDLE, GRANT}, ptr[2:0] (highest-priority index), gnt_idx, hold_cnt, preempt.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise the winner is the first set bit scanning ptr, ptr+1, ..., ptr+7 (mod 8).
  - On the next edge: gnt_idx=winner, gnt_valid=1, hold_cnt=0, go to GRANT.
  - Latency: req sampled at edge t gives gnt visible after edge t+1 (one cycle).
- GRANT, release conditions checked each edge:
  - (a) done=1, or (b) req[gnt_idx]=0: normal release.
  - (c) hold_cnt==HOLD_MAX-1 with neither (a) nor (b): timeout release; preempt=1 for exactly the next cycle.
  - On any release: go to IDLE, gnt_valid=0, ptr=gnt_idx+1 (mod 8, so 7 wraps to 0).
  - Otherwise hold_cnt increments and the grant holds.
- Simultaneous events:
  - done and timeout together counts as normal release, preempt=0.
  - Request changes on non-owner lines during GRANT are ignored.
  - done in IDLE is ignored.
- Grant timing:
  - Each grant lasts at most HOLD_MAX cycles.
  - There is a mandatory one-cycle gnt_valid=0 bubble between consecutive grants, so the handover is never glitchy.
- Output decoding:
  - gnt = decode(gnt_idx) AND {8{gnt_valid}}.
  - This is combinational from registers only, with no input-to-output path.
- Fairness: with all 8 lines requesting continuously, grants visit indices 0,1,...,7,0,... with no skips.
- Width rules: ptr and gnt_idx arithmetic is modulo 8 (natural 3-bit overflow). hold_cnt never exceeds HOLD_MAX-1.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1
  - N_REQ=8, IDX_W=3
- Sub-module gnt_decoder: 3-to-8 one-hot decoder with enable (inputs idx[2:0], en; output y[7:0]), built from gate primitives. It is instantiated once for gnt.
- The rotating priority search stays in the top module as a combinational function.

Test Plan:
- Reset: assert rst_n=0 mid-grant -> gnt=8'h00, gnt_valid=0, preempt=0 immediately. After release with req=0 -> outputs stay zero.
- Single requester: req=8'h04 held, done pulsed on the 3rd grant cycle -> gnt=8'h04 one cycle after req, gnt_idx=2. Then gnt_valid=0 for one cycle, then regranted to 2 (ptr=3, but 2 is the only requester).
- Full rotation: req=8'hFF, done pulsed every grant cycle -> gnt_idx sequence 0,1,2,...,7,0, each grant followed by one bubble cycle.
- Wrap/priority: ptr=7 after granting 6, req=8'h81 -> next grant is idx 7. After its release, next grant is idx 0.
- Timeout with HOLD_MAX=4: req=8'h10 held, done=0 -> gnt=8'h10 for exactly 4 cycles, then preempt=1 for one cycle and gnt_valid=0 for one cycle.
- Owner drops request: req=8'h22, owner idx 1 deasserts req[1] after 2 cycles -> release, bubble, then grant idx 5 with preempt=0. Also, done coinciding with the timeout edge -> preempt stays 0.
